fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Receives the registered jump request produced at the end of the execute stage and turns it into a front-end redirect. It pulses a pipeline flush, issues sysreg side-effect requests, then performs a handshaked PC load into fetch. Its busy output stalls the execute-side jump register while a redirect is in flight. It also keeps saturating branch-prediction hit/miss counters.

## Interface
Parameters:
- P_CNT_W, 16, width of each prediction statistics counter

Ports:
- iCLOCK  in  1  core clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous reset: aborts any redirect and clears the counters
- iEVENT_HOLD  in  1  synchronous abort: returns the FSM to IDLE; counters are kept
- iPREV_PREDICT_ENA  in  1  prediction was used for this branch
- iPREV_PREDICT_HIT  in  1  prediction was correct
- iPREV_JUMP_VALID  in  1  redirect request
- iPREV_JUMP_ADDR  in  32  redirect target
- iPREV_TYPE_BRANCH_VALID  in  1  normal branch mispredict
- iPREV_TYPE_BRANCH_IB_VALID  in  1  indirect branch
- iPREV_TYPE_SYSREG_IDT_VALID  in  1  IDT write
- iPREV_TYPE_SYSREG_PDT_VALID  in  1  PDT write
- iPREV_TYPE_SYSREG_PSR_VALID  in  1  PSR write
- oPREV_BUSY  out  1  stall to execute
- oFLUSH  out  1  one-cycle pipeline flush pulse
- oIDT_RELOAD  out  1  one-cycle IDT reload pulse
- oPSR_RELOAD  out  1  one-cycle PSR reload pulse
- oTLB_FLUSH_REQ  out  1  TLB flush request, held until acknowledged
- iTLB_FLUSH_ACK  in  1  TLB flush done
- oFETCH_PC_SET_VALID  out  1  PC load request, held until accepted
- oFETCH_PC_SET_ADDR  out  32  PC to load
- iFETCH_PC_SET_BUSY  in  1  fetch cannot accept a PC load this cycle
- oSTAT_HIT_CNT  out  P_CNT_W  count of correct predictions
- oSTAT_MISS_CNT  out  P_CNT_W  count of incorrect predictions

## Operation
- Accept cycle: a cycle in which the FSM is in IDLE. oPREV_BUSY is 0 exactly in IDLE and is driven from the registered state only.
- Capture: in an accept cycle with iPREV_JUMP_VALID=1, register the address with bits [1:0] forced to 0, register all five type flags, and go to FLUSH. If iPREV_JUMP_VALID=1 with every type flag 0, the request is still treated as a normal redirect.
- FSM states: IDLE, FLUSH, TLB, SETPC.
  - FLUSH (one cycle): oFLUSH=1. oIDT_RELOAD=1 if the captured IDT flag is set. oPSR_RELOAD=1 if the captured PSR flag is set. Next state is TLB if the captured PDT flag is set, otherwise SETPC.
  - TLB: oTLB_FLUSH_REQ=1. Go to SETPC on the cycle iTLB_FLUSH_ACK=1. An ACK that arrives while not in TLB is ignored.
  - SETPC: oFETCH_PC_SET_VALID=1 and oFETCH_PC_SET_ADDR holds the captured address. The transfer completes on any cycle with iFETCH_PC_SET_BUSY=0; then go to IDLE. The address must stay stable while the request is held.
- Statistics: in an accept cycle with iPREV_PREDICT_ENA=1, increment the hit counter if iPREV_PREDICT_HIT=1, otherwise the miss counter. This applies whether or not iPREV_JUMP_VALID is set. Both counters saturate at all-ones. Inputs in non-accept cycles are ignored.
- Priority: inRESET > iRESET_SYNC > iEVENT_HOLD > normal operation. Both iRESET_SYNC and iEVENT_HOLD force IDLE and drive all request and pulse outputs to 0 on the following cycle. A request that arrives in the same cycle as either of them is dropped.

## Timing
- Reset values: state IDLE; every output 0, including oFETCH_PC_SET_ADDR and both counters.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Capture at edge T:
  - cycle T+1: oFLUSH=1 and oPREV_BUSY=1.
  - cycle T+2, no PDT: oFETCH_PC_SET_VALID=1.
  - fetch not busy: IDLE again, so oPREV_BUSY=0 in cycle T+3.
  - Minimum redirect cost: 2 busy cycles.
- PDT redirect: each TLB wait cycle and each cycle with iFETCH_PC_SET_BUSY=1 adds exactly one cycle.
- Back-to-back requests: a new request can be captured in the first IDLE cycle after completion. No bubble is required beyond that.

## Test plan
- Normal redirect: JUMP_VALID with ADDR=0x0000_1003 and BRANCH=1, fetch idle. Required: oFLUSH at T+1; VALID with ADDR=0x0000_1000 at T+2; busy high exactly 2 cycles.
- PDT plus PSR redirect: ACK delayed 3 cycles. Required: oPSR_RELOAD with oFLUSH at T+1; oTLB_FLUSH_REQ held for cycles T+2 to T+5; PC load at T+6.
- Fetch backpressure: iFETCH_PC_SET_BUSY=1 for 4 cycles during SETPC. Required: VALID and ADDR held stable for 5 cycles; return to IDLE after the first non-busy cycle.
- Statistics: 3 hits and 2 misses in accept cycles, plus 2 hits presented while busy. Required: HIT=3, MISS=2. With P_CNT_W=4, 20 hits give HIT=15.
- Abort: iEVENT_HOLD in SETPC. Required: next cycle IDLE with all request outputs 0 and counters unchanged. iRESET_SYNC additionally gives counters 0.
- Async reset mid-TLB: inRESET low. Required: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - execute-to-fetch redirect signal bundle
// master drives the jump request and fetch/TLB responses; slave is the redirect controller.
interface fetch_redirect_ctrl_if #(
  parameter int P_CNT_W = 16
);
  logic               iRESET_SYNC;
  logic               iEVENT_HOLD;
  logic               iPREV_PREDICT_ENA;
  logic               iPREV_PREDICT_HIT;
  logic               iPREV_JUMP_VALID;
  logic [31:0]        iPREV_JUMP_ADDR;
  logic               iPREV_TYPE_BRANCH_VALID;
  logic               iPREV_TYPE_BRANCH_IB_VALID;
  logic               iPREV_TYPE_SYSREG_IDT_VALID;
  logic               iPREV_TYPE_SYSREG_PDT_VALID;
  logic               iPREV_TYPE_SYSREG_PSR_VALID;
  logic               oPREV_BUSY;
  logic               oFLUSH;
  logic               oIDT_RELOAD;
  logic               oPSR_RELOAD;
  logic               oTLB_FLUSH_REQ;
  logic               iTLB_FLUSH_ACK;
  logic               oFETCH_PC_SET_VALID;
  logic [31:0]        oFETCH_PC_SET_ADDR;
  logic               iFETCH_PC_SET_BUSY;
  logic [P_CNT_W-1:0] oSTAT_HIT_CNT;
  logic [P_CNT_W-1:0] oSTAT_MISS_CNT;

  modport master (
    output iRESET_SYNC, iEVENT_HOLD, iPREV_PREDICT_ENA, iPREV_PREDICT_HIT,
           iPREV_JUMP_VALID, iPREV_JUMP_ADDR, iPREV_TYPE_BRANCH_VALID,
           iPREV_TYPE_BRANCH_IB_VALID, iPREV_TYPE_SYSREG_IDT_VALID,
           iPREV_TYPE_SYSREG_PDT_VALID, iPREV_TYPE_SYSREG_PSR_VALID,
           iTLB_FLUSH_ACK, iFETCH_PC_SET_BUSY,
    input  oPREV_BUSY, oFLUSH, oIDT_RELOAD, oPSR_RELOAD, oTLB_FLUSH_REQ,
           oFETCH_PC_SET_VALID, oFETCH_PC_SET_ADDR, oSTAT_HIT_CNT, oSTAT_MISS_CNT
  );

  modport slave (
    input  iRESET_SYNC, iEVENT_HOLD, iPREV_PREDICT_ENA, iPREV_PREDICT_HIT,
           iPREV_JUMP_VALID, iPREV_JUMP_ADDR, iPREV_TYPE_BRANCH_VALID,
           iPREV_TYPE_BRANCH_IB_VALID, iPREV_TYPE_SYSREG_IDT_VALID,
           iPREV_TYPE_SYSREG_PDT_VALID, iPREV_TYPE_SYSREG_PSR_VALID,
           iTLB_FLUSH_ACK, iFETCH_PC_SET_BUSY,
    output oPREV_BUSY, oFLUSH, oIDT_RELOAD, oPSR_RELOAD, oTLB_FLUSH_REQ,
           oFETCH_PC_SET_VALID, oFETCH_PC_SET_ADDR, oSTAT_HIT_CNT, oSTAT_MISS_CNT
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - turns a registered jump into flush, sysreg pulses and a PC load
// Every output is decoded from registered state, so async reset clears them without a clock.
module fetch_redirect_ctrl #(
  parameter int P_CNT_W = 16
) (
  input  logic                  iCLOCK,
  input  logic                  inRESET,
  fetch_redirect_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_TLB, S_SETPC} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [4:0]         type_q, type_d;
  logic [P_CNT_W-1:0] hit_q, hit_d;
  logic [P_CNT_W-1:0] miss_q, miss_d;
  logic               accept;

  // type_q bit order: {psr, pdt, idt, ib, branch}
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    accept  = (state_q == S_IDLE);
    if (bus.iRESET_SYNC) begin
      state_d = S_IDLE;
      hit_d   = '0;
      miss_d  = '0;
    end else if (bus.iEVENT_HOLD) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.iPREV_JUMP_VALID) begin
            addr_d  = {bus.iPREV_JUMP_ADDR[31:2], 2'b00};
            type_d  = {bus.iPREV_TYPE_SYSREG_PSR_VALID, bus.iPREV_TYPE_SYSREG_PDT_VALID,
                       bus.iPREV_TYPE_SYSREG_IDT_VALID, bus.iPREV_TYPE_BRANCH_IB_VALID,
                       bus.iPREV_TYPE_BRANCH_VALID};
            state_d = S_FLUSH;
          end
        end
        S_FLUSH: state_d = type_q[3] ? S_TLB : S_SETPC;
        S_TLB:   if (bus.iTLB_FLUSH_ACK) state_d = S_SETPC;
        S_SETPC: if (!bus.iFETCH_PC_SET_BUSY) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      // Prediction statistics are sampled only while the execute side is not stalled.
      if (accept && bus.iPREV_PREDICT_ENA) begin
        if (bus.iPREV_PREDICT_HIT) begin
          if (hit_q != '1) hit_d = hit_q + P_CNT_W'(1);
        end else begin
          if (miss_q != '1) miss_d = miss_q + P_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Branch/indirect flags are captured for completeness; both simply redirect normally.
  assign bus.oPREV_BUSY          = (state_q != S_IDLE);
  assign bus.oFLUSH              = (state_q == S_FLUSH);
  assign bus.oIDT_RELOAD         = (state_q == S_FLUSH) && type_q[2];
  assign bus.oPSR_RELOAD         = (state_q == S_FLUSH) && type_q[4];
  assign bus.oTLB_FLUSH_REQ      = (state_q == S_TLB);
  assign bus.oFETCH_PC_SET_VALID = (state_q == S_SETPC);
  assign bus.oFETCH_PC_SET_ADDR  = addr_q;
  assign bus.oSTAT_HIT_CNT       = hit_q;
  assign bus.oSTAT_MISS_CNT      = miss_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_fetch_redirect_ctrl;
  logic iCLOCK = 1'b0;
  logic inRESET = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fetch_redirect_ctrl_if #(.P_CNT_W(4)) bus ();

  fetch_redirect_ctrl #(.P_CNT_W(4)) dut (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .bus    (bus)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    bus.iPREV_JUMP_VALID            = 1'b0;
    bus.iPREV_JUMP_ADDR             = 32'h0;
    bus.iPREV_TYPE_BRANCH_VALID     = 1'b0;
    bus.iPREV_TYPE_BRANCH_IB_VALID  = 1'b0;
    bus.iPREV_TYPE_SYSREG_IDT_VALID = 1'b0;
    bus.iPREV_TYPE_SYSREG_PDT_VALID = 1'b0;
    bus.iPREV_TYPE_SYSREG_PSR_VALID = 1'b0;
    bus.iPREV_PREDICT_ENA           = 1'b0;
    bus.iPREV_PREDICT_HIT           = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.oPREV_BUSY), 32'h0);
    chk({tag, "_flush"}, 32'(bus.oFLUSH), 32'h0);
    chk({tag, "_idt"},   32'(bus.oIDT_RELOAD), 32'h0);
    chk({tag, "_psr"},   32'(bus.oPSR_RELOAD), 32'h0);
    chk({tag, "_tlb"},   32'(bus.oTLB_FLUSH_REQ), 32'h0);
    chk({tag, "_valid"}, 32'(bus.oFETCH_PC_SET_VALID), 32'h0);
  endtask

  initial begin
    clear_req();
    bus.iRESET_SYNC        = 1'b0;
    bus.iEVENT_HOLD        = 1'b0;
    bus.iTLB_FLUSH_ACK     = 1'b0;
    bus.iFETCH_PC_SET_BUSY = 1'b0;
    tick();
    tick();
    all_zero("rst");
    chk("rst_addr", bus.oFETCH_PC_SET_ADDR, 32'h0);
    chk("rst_hit",  32'(bus.oSTAT_HIT_CNT), 32'h0);
    chk("rst_miss", 32'(bus.oSTAT_MISS_CNT), 32'h0);
    inRESET = 1'b1;
    tick();

    // Normal redirect: 2 busy cycles, low address bits dropped.
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_1003;
    bus.iPREV_TYPE_BRANCH_VALID = 1'b1;
    tick(); clear_req();
    chk("n_flush_t1", 32'(bus.oFLUSH), 32'h1);
    chk("n_busy_t1",  32'(bus.oPREV_BUSY), 32'h1);
    chk("n_valid_t1", 32'(bus.oFETCH_PC_SET_VALID), 32'h0);
    chk("n_idt_t1",   32'(bus.oIDT_RELOAD), 32'h0);
    tick();
    chk("n_valid_t2", 32'(bus.oFETCH_PC_SET_VALID), 32'h1);
    chk("n_addr_t2",  bus.oFETCH_PC_SET_ADDR, 32'h0000_1000);
    chk("n_flush_t2", 32'(bus.oFLUSH), 32'h0);
    chk("n_busy_t2",  32'(bus.oPREV_BUSY), 32'h1);
    tick();
    chk("n_busy_t3",  32'(bus.oPREV_BUSY), 32'h0);
    chk("n_valid_t3", 32'(bus.oFETCH_PC_SET_VALID), 32'h0);

    // Stray ACK while idle must not matter; PDT+PSR redirect with ACK in cycle T+5.
    bus.iTLB_FLUSH_ACK = 1'b1; tick(); bus.iTLB_FLUSH_ACK = 1'b0;
    chk("ack_idle_busy", 32'(bus.oPREV_BUSY), 32'h0);
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_2002;
    bus.iPREV_TYPE_SYSREG_PDT_VALID = 1'b1; bus.iPREV_TYPE_SYSREG_PSR_VALID = 1'b1;
    tick(); clear_req();
    chk("p_flush_t1", 32'(bus.oFLUSH), 32'h1);
    chk("p_psr_t1",   32'(bus.oPSR_RELOAD), 32'h1);
    chk("p_idt_t1",   32'(bus.oIDT_RELOAD), 32'h0);
    chk("p_tlb_t1",   32'(bus.oTLB_FLUSH_REQ), 32'h0);
    tick();
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("p_tlb_t%0d", i),   32'(bus.oTLB_FLUSH_REQ), 32'h1);
      chk($sformatf("p_valid_t%0d", i), 32'(bus.oFETCH_PC_SET_VALID), 32'h0);
      chk($sformatf("p_psr_t%0d", i),   32'(bus.oPSR_RELOAD), 32'h0);
      if (i == 5) bus.iTLB_FLUSH_ACK = 1'b1;
      tick();
    end
    bus.iTLB_FLUSH_ACK = 1'b0;
    chk("p_tlb_t6",   32'(bus.oTLB_FLUSH_REQ), 32'h0);
    chk("p_valid_t6", 32'(bus.oFETCH_PC_SET_VALID), 32'h1);
    chk("p_addr_t6",  bus.oFETCH_PC_SET_ADDR, 32'h0000_2000);
    tick();
    chk("p_busy_t7",  32'(bus.oPREV_BUSY), 32'h0);

    // Fetch backpressure: VALID/ADDR held 5 cycles.
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_3007;
    bus.iPREV_TYPE_BRANCH_IB_VALID = 1'b1;
    tick(); clear_req();
    bus.iFETCH_PC_SET_BUSY = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_valid_%0d", i), 32'(bus.oFETCH_PC_SET_VALID), 32'h1);
      chk($sformatf("b_addr_%0d", i),  bus.oFETCH_PC_SET_ADDR, 32'h0000_3004);
      tick();
    end
    bus.iFETCH_PC_SET_BUSY = 1'b0;
    chk("b_valid_4", 32'(bus.oFETCH_PC_SET_VALID), 32'h1);
    chk("b_addr_4",  bus.oFETCH_PC_SET_ADDR, 32'h0000_3004);
    tick();
    chk("b_busy_end",  32'(bus.oPREV_BUSY), 32'h0);
    chk("b_valid_end", 32'(bus.oFETCH_PC_SET_VALID), 32'h0);

    // Back-to-back: new IDT request captured in the first IDLE cycle.
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_5000;
    bus.iPREV_TYPE_SYSREG_IDT_VALID = 1'b1;
    tick(); clear_req();
    chk("bb_flush", 32'(bus.oFLUSH), 32'h1);
    chk("bb_idt",   32'(bus.oIDT_RELOAD), 32'h1);
    tick(); tick();
    chk("bb_idle",  32'(bus.oPREV_BUSY), 32'h0);

    // Statistics: 3 hits, 2 misses accepted; 2 hits while busy ignored.
    for (int i = 0; i < 5; i++) begin
      bus.iPREV_PREDICT_ENA = 1'b1; bus.iPREV_PREDICT_HIT = (i < 3);
      tick();
    end
    clear_req();
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_6000;
    tick(); clear_req();
    bus.iPREV_PREDICT_ENA = 1'b1; bus.iPREV_PREDICT_HIT = 1'b1;
    tick(); tick();
    clear_req();
    chk("s_busy_end", 32'(bus.oPREV_BUSY), 32'h0);
    chk("s_hit",  32'(bus.oSTAT_HIT_CNT), 32'd3);
    chk("s_miss", 32'(bus.oSTAT_MISS_CNT), 32'd2);
    bus.iPREV_PREDICT_ENA = 1'b1; bus.iPREV_PREDICT_HIT = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    clear_req();
    chk("s_hit_sat",  32'(bus.oSTAT_HIT_CNT), 32'd15);
    chk("s_miss_sat", 32'(bus.oSTAT_MISS_CNT), 32'd2);

    // Abort with iEVENT_HOLD in SETPC.
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_4000;
    bus.iFETCH_PC_SET_BUSY = 1'b1;
    tick(); clear_req(); tick();
    chk("h_valid_pre", 32'(bus.oFETCH_PC_SET_VALID), 32'h1);
    bus.iEVENT_HOLD = 1'b1;
    tick();
    bus.iEVENT_HOLD = 1'b0; bus.iFETCH_PC_SET_BUSY = 1'b0;
    all_zero("h_post");
    chk("h_hit",  32'(bus.oSTAT_HIT_CNT), 32'd15);
    chk("h_miss", 32'(bus.oSTAT_MISS_CNT), 32'd2);

    // Request coinciding with iEVENT_HOLD is dropped, and its prediction not counted.
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_7000;
    bus.iPREV_PREDICT_ENA = 1'b1; bus.iEVENT_HOLD = 1'b1;
    tick(); clear_req(); bus.iEVENT_HOLD = 1'b0;
    chk("hd_busy", 32'(bus.oPREV_BUSY), 32'h0);
    chk("hd_miss", 32'(bus.oSTAT_MISS_CNT), 32'd2);

    // iRESET_SYNC mid-redirect: IDLE and counters cleared.
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_8000;
    tick(); clear_req();
    chk("rs_flush", 32'(bus.oFLUSH), 32'h1);
    bus.iRESET_SYNC = 1'b1;
    tick();
    bus.iRESET_SYNC = 1'b0;
    all_zero("rs_post");
    chk("rs_hit",  32'(bus.oSTAT_HIT_CNT), 32'h0);
    chk("rs_miss", 32'(bus.oSTAT_MISS_CNT), 32'h0);

    // Async reset mid-TLB; prediction hit counted on a jump accept cycle.
    bus.iPREV_JUMP_VALID = 1'b1; bus.iPREV_JUMP_ADDR = 32'h0000_9000;
    bus.iPREV_TYPE_SYSREG_PDT_VALID = 1'b1;
    bus.iPREV_PREDICT_ENA = 1'b1; bus.iPREV_PREDICT_HIT = 1'b1;
    tick(); clear_req();
    chk("a_hit_jump", 32'(bus.oSTAT_HIT_CNT), 32'd1);
    tick();
    chk("a_tlb", 32'(bus.oTLB_FLUSH_REQ), 32'h1);
    #2 inRESET = 1'b0;
    #1;
    all_zero("a_async");
    chk("a_addr", bus.oFETCH_PC_SET_ADDR, 32'h0);
    chk("a_hit",  32'(bus.oSTAT_HIT_CNT), 32'h0);
    tick();
    inRESET = 1'b1;
    tick();
    chk("a_idle", 32'(bus.oPREV_BUSY), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
